// File: rtl/trigger_qualifier.sv
// Comparator conditioning: synchroniser, glitch filter, period meter and
// frequency-lock tracker feeding the ping-pong capture buffer.
module trigger_qualifier #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 4,
    parameter int CNT_WIDTH    = 24,
    parameter int TOL_SHIFT    = 4,
    parameter int STABLE_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 comp_in,
    output logic                 signal_out,
    output logic                 rise_pulse,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 stable
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int MW = $clog2(STABLE_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_TRACK,
        S_LOCKED
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], comp_in};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    logic [FW-1:0] r_fcnt;
    logic          r_sig;
    logic          r_rise;
    logic          w_flip;
    logic          w_rise;

    // w_rise fires one cycle ahead so that the period update, the lock
    // flag and rise_pulse all become visible in the same cycle.
    assign w_flip = (w_s != r_sig) && (r_fcnt == FW'(FILTER_LEN - 1));
    assign w_rise = w_flip && w_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt <= '0;
            r_sig  <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_rise <= w_rise;
            if (w_s == r_sig) begin
                r_fcnt <= '0;
            end else if (w_flip) begin
                r_fcnt <= '0;
                r_sig  <= w_s;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    logic [CNT_WIDTH-1:0] r_pcnt;
    logic                 w_sat;

    assign w_sat = (r_pcnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_rise) begin
            r_pcnt <= CNT_WIDTH'(1);
        end else if (!w_sat) begin
            r_pcnt <= r_pcnt + 1'b1;
        end
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] w_period_nxt;
    logic [MW-1:0]        r_match;
    logic [MW-1:0]        w_match_nxt;
    logic                 r_pvalid;
    logic                 w_pvalid_nxt;
    logic [CNT_WIDTH:0]   w_diff;
    logic [CNT_WIDTH:0]   w_tol;
    logic                 w_in_tol;

    // One extra bit keeps the absolute difference free of wrap-around.
    assign w_diff = (r_pcnt >= r_period)
                  ? ({1'b0, r_pcnt} - {1'b0, r_period})
                  : ({1'b0, r_period} - {1'b0, r_pcnt});
    assign w_tol    = {1'b0, r_period >> TOL_SHIFT};
    assign w_in_tol = (w_diff <= w_tol);

    always_comb begin
        w_state_nxt  = r_state;
        w_period_nxt = r_period;
        w_match_nxt  = r_match;
        w_pvalid_nxt = 1'b0;
        if (w_rise) begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FIRST;
                end
                S_FIRST: begin
                    w_period_nxt = r_pcnt;
                    w_pvalid_nxt = 1'b1;
                    w_match_nxt  = '0;
                    w_state_nxt  = S_TRACK;
                end
                S_TRACK: begin
                    w_period_nxt = r_pcnt;
                    w_pvalid_nxt = 1'b1;
                    if (w_in_tol) begin
                        w_match_nxt = r_match + 1'b1;
                        if (r_match == MW'(STABLE_COUNT - 1)) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    w_period_nxt = r_pcnt;
                    w_pvalid_nxt = 1'b1;
                    if (!w_in_tol) begin
                        w_match_nxt = '0;
                        w_state_nxt = S_TRACK;
                    end
                end
            endcase
        end else if ((r_state != S_IDLE) && w_sat) begin
            w_state_nxt  = S_IDLE;
            w_period_nxt = '0;
            w_match_nxt  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_period <= '0;
            r_match  <= '0;
            r_pvalid <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_period <= w_period_nxt;
            r_match  <= w_match_nxt;
            r_pvalid <= w_pvalid_nxt;
        end
    end

    assign signal_out   = r_sig;
    assign rise_pulse   = r_rise;
    assign period       = r_period;
    assign period_valid = r_pvalid;
    assign stable       = (r_state == S_LOCKED);

endmodule

// File: tb/tb_trigger_qualifier.sv
// Bench for trigger_qualifier: glitch table, lock/tolerance/timeout/reset
// sequences and random waveforms checked against an event-level model.
module tb_trigger_qualifier;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int CW   = 8;
    localparam int TOL  = 4;
    localparam int STBL = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          comp_in;
    logic          signal_out;
    logic          rise_pulse;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          stable;

    always #5 clk = ~clk;

    trigger_qualifier #(
        .SYNC_STAGES (SYNC),
        .FILTER_LEN  (FILT),
        .CNT_WIDTH   (CW),
        .TOL_SHIFT   (TOL),
        .STABLE_COUNT(STBL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .comp_in     (comp_in),
        .signal_out  (signal_out),
        .rise_pulse  (rise_pulse),
        .period      (period),
        .period_valid(period_valid),
        .stable      (stable)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Event-level model: mode 0 idle, 1 first, 2 track, 3 locked.
    bit m_syn[SYNC];
    bit m_sh[FILT];
    bit m_out, m_rise, m_pv;
    int m_mode, m_period, m_match, m_n, m_lr;

    function automatic void model_step();
        bit pre, flip, old;
        int p, d;
        m_pv   = 0;
        m_rise = 0;
        m_n++;
        if (rst) begin
            for (int i = 0; i < SYNC; i++) m_syn[i] = 0;
            for (int i = 0; i < FILT; i++) m_sh[i] = 0;
            m_out    = 0;
            m_mode   = 0;
            m_period = 0;
            m_match  = 0;
        end else begin
            pre = m_syn[SYNC-1];
            for (int i = FILT - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = pre;
            flip = 1;
            for (int i = 0; i < FILT; i++) if (m_sh[i] == m_out) flip = 0;
            for (int i = SYNC - 1; i > 0; i--) m_syn[i] = m_syn[i-1];
            m_syn[0] = comp_in;
            old = m_out;
            if (flip) m_out = ~m_out;
            m_rise = !old && m_out;
            if (m_rise) begin
                if (m_mode == 0) begin
                    m_mode = 1;
                end else begin
                    p    = m_n - m_lr;
                    m_pv = 1;
                    d    = p - m_period;
                    if (d < 0) d = -d;
                    if (m_mode == 1) begin
                        m_match = 0;
                        m_mode  = 2;
                    end else if (m_mode == 2) begin
                        if (d <= (m_period >> TOL)) begin
                            m_match++;
                            if (m_match == STBL) m_mode = 3;
                        end else begin
                            m_match = 0;
                        end
                    end else if (d > (m_period >> TOL)) begin
                        m_match = 0;
                        m_mode  = 2;
                    end
                    m_period = p;
                end
                m_lr = m_n;
            end else if (m_mode != 0 && (m_n - m_lr) == MAXC) begin
                m_mode   = 0;
                m_period = 0;
                m_match  = 0;
            end
        end
    endfunction

    int rise_cnt, pv_cnt, stable_at, per2;
    bit prev_stable;

    task automatic clr_stats();
        rise_cnt  = 0;
        pv_cnt    = 0;
        stable_at = -1;
        per2      = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("signal_out", int'(signal_out), int'(m_out));
        chk("rise_pulse", int'(rise_pulse), int'(m_rise));
        chk("period_valid", int'(period_valid), int'(m_pv));
        chk("period", int'(period), m_period);
        chk("stable", int'(stable), int'(m_mode == 3));
        if (rise_pulse) begin
            rise_cnt++;
            if (rise_cnt == 2 && period_valid) per2 = int'(period);
        end
        if (period_valid) pv_cnt++;
        if (stable && !prev_stable) stable_at = rise_cnt;
        prev_stable = stable;
    endtask

    task automatic drive(input bit v, input int n);
        comp_in = v;
        repeat (n) tick();
    endtask

    task automatic wave(input int hi, input int lo);
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) begin
            comp_in = ~comp_in;
            tick();
        end
        chk("rst_signal_out", int'(signal_out), 0);
        chk("rst_rise", int'(rise_pulse), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_pvalid", int'(period_valid), 0);
        chk("rst_stable", int'(stable), 0);
        rst     = 1'b0;
        comp_in = 1'b0;
    endtask

    typedef struct {
        int len;
        int exp_high;
        int exp_delay;
    } gvec_t;

    gvec_t gv[5];

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, first, high, pv0, base, hi, lo, r;
        gv[0] = '{1, 0, -1};
        gv[1] = '{3, 0, -1};
        gv[2] = '{4, 4, 6};
        gv[3] = '{5, 5, 6};
        gv[4] = '{9, 9, 6};
        rst = 1'b1;
        comp_in = 1'b0;
        prev_stable = 0;
        m_n = 0;
        m_lr = 0;
        clr_stats();

        do_reset();
        comp_in = 1'b1;
        d = 0;
        while (!rise_pulse && d < 20) begin
            tick();
            d++;
        end
        chk("reset_rise_delay", d, SYNC + FILT);

        foreach (gv[k]) begin
            drive(1'b0, 20);
            first = -1;
            high  = 0;
            for (int i = 0; i < gv[k].len + 30; i++) begin
                comp_in = (i < gv[k].len);
                tick();
                if (signal_out) begin
                    high++;
                    if (first < 0) first = i + 1;
                end
            end
            chk($sformatf("glitch%0d_high", gv[k].len), high, gv[k].exp_high);
            chk($sformatf("glitch%0d_delay", gv[k].len), first, gv[k].exp_delay);
        end

        do_reset();
        drive(1'b0, 10);
        clr_stats();
        repeat (6) wave(50, 50);
        chk("lock_rises", rise_cnt, 6);
        chk("lock_stable_at", stable_at, 6);
        chk("lock_period2", per2, 100);
        chk("lock_stable", int'(stable), 1);

        wave(53, 53);
        wave(56, 57);
        chk("tol106_stable", int'(stable), 1);
        chk("tol106_period", int'(period), 106);
        wave(56, 57);
        chk("tol113_stable", int'(stable), 0);
        chk("tol113_period", int'(period), 113);
        repeat (3) wave(56, 57);
        chk("relock3_stable", int'(stable), 0);
        drive(1'b1, 10);
        chk("relock4_stable", int'(stable), 1);

        drive(1'b1, 46);
        drive(1'b0, 300);
        chk("timeout_stable", int'(stable), 0);
        chk("timeout_period", int'(period), 0);
        pv0 = pv_cnt;
        wave(50, 50);
        chk("timeout_first_pv", pv_cnt - pv0, 0);
        wave(50, 50);
        chk("timeout_track_pv", pv_cnt - pv0, 1);
        chk("timeout_track_period", int'(period), 100);
        repeat (4) wave(50, 50);
        chk("pre_rst_stable", int'(stable), 1);

        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_stable", int'(stable), 0);
        chk("async_rst_period", int'(period), 0);
        tick();
        rst = 1'b0;
        clr_stats();
        repeat (5) wave(50, 50);
        chk("rst_relock5_stable", int'(stable), 0);
        wave(50, 50);
        chk("rst_relock_stable_at", stable_at, 6);
        chk("rst_relock_rises", rise_cnt, 6);

        base = 80;
        for (int s = 0; s < 60; s++) begin
            if (s % 8 == 0) base = $urandom_range(40, 120);
            r = $urandom_range(0, 9);
            if (r < 6) begin
                hi = base / 2 + $urandom_range(0, 1);
                lo = base - base / 2 + $urandom_range(0, 1);
            end else if (r < 8) begin
                hi = $urandom_range(1, 6);
                lo = $urandom_range(1, 6);
            end else begin
                hi = $urandom_range(5, 40);
                lo = $urandom_range(240, 280);
            end
            wave(hi, lo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
